// File: rtl/intersection_pkg.sv
// Shared light codes and phase encodings for the intersection controller.
package intersection_pkg;

  localparam logic [2:0] RED    = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b100;

  localparam logic [2:0] PH_MAIN_GRN = 3'd0;
  localparam logic [2:0] PH_MAIN_YEL = 3'd1;
  localparam logic [2:0] PH_RED_A    = 3'd2;
  localparam logic [2:0] PH_SIDE_GRN = 3'd3;
  localparam logic [2:0] PH_SIDE_YEL = 3'd4;
  localparam logic [2:0] PH_RED_B    = 3'd5;

  typedef enum logic [2:0] {
    ST_MAIN_GRN = PH_MAIN_GRN,
    ST_MAIN_YEL = PH_MAIN_YEL,
    ST_RED_A    = PH_RED_A,
    ST_SIDE_GRN = PH_SIDE_GRN,
    ST_SIDE_YEL = PH_SIDE_YEL,
    ST_RED_B    = PH_RED_B
  } phase_e;

endpackage

// File: rtl/intersection_controller_phase_timer.sv
// Saturating phase timer; clr restarts the count and wins over counting.
module phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic [TW-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (cnt != {TW{1'b1}})
      cnt <= cnt + TW'(1);
  end

endmodule

// File: rtl/intersection_controller.sv
// Two-head intersection sequencer with latched side request.
// Optional pedestrian walk support is enabled with `define PED_WALK_EN.
module intersection_controller
  import intersection_pkg::*;
#(
  parameter int MAIN_MIN = 8,
  parameter int SIDE_GRN = 6,
  parameter int YEL      = 3,
  parameter int ALL_RED  = 1,
  parameter int TW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
`ifdef PED_WALK_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic [2:0] phase,
  output logic       side_served
);

  localparam logic [TW-1:0] MAIN_LAST = TW'(MAIN_MIN - 1);
  localparam logic [TW-1:0] SIDE_LAST = TW'(SIDE_GRN - 1);
  localparam logic [TW-1:0] YEL_LAST  = TW'(YEL - 1);
  localparam logic [TW-1:0] RED_LAST  = TW'(ALL_RED - 1);

  phase_e        state, nxt;
  logic [TW-1:0] timer;
  logic          req_q;
  logic          eff_req;
  logic          entering_side;
  logic          clr;

  function automatic logic [5:0] light_pair(input phase_e s);
    case (s)
      ST_MAIN_GRN: light_pair = {GREEN,  RED};
      ST_MAIN_YEL: light_pair = {YELLOW, RED};
      ST_SIDE_GRN: light_pair = {RED,    GREEN};
      ST_SIDE_YEL: light_pair = {RED,    YELLOW};
      default:     light_pair = {RED,    RED};
    endcase
  endfunction

`ifdef PED_WALK_EN
  logic ped_q;
  assign eff_req = req_q | side_req | ped_q | ped_req;
`else
  assign eff_req = req_q | side_req;
`endif

  phase_timer #(.TW(TW)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .cnt (timer)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_MAIN_GRN: if (timer >= MAIN_LAST && eff_req) nxt = ST_MAIN_YEL;
      ST_MAIN_YEL: if (timer == YEL_LAST)  nxt = ST_RED_A;
      ST_RED_A:    if (timer == RED_LAST)  nxt = ST_SIDE_GRN;
      ST_SIDE_GRN: if (timer == SIDE_LAST) nxt = ST_SIDE_YEL;
      ST_SIDE_YEL: if (timer == YEL_LAST)  nxt = ST_RED_B;
      ST_RED_B:    if (timer == RED_LAST)  nxt = ST_MAIN_GRN;
      default:     nxt = ST_MAIN_GRN;
    endcase
    clr           = (nxt != state);
    entering_side = (nxt == ST_SIDE_GRN) && (state != ST_SIDE_GRN);
  end

  // Outputs are registered from next-state so lights and phase move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_MAIN_GRN;
      req_q       <= 1'b0;
      main_light  <= GREEN;
      side_light  <= RED;
      phase       <= PH_MAIN_GRN;
      side_served <= 1'b0;
    end else begin
      state                    <= nxt;
      {main_light, side_light} <= light_pair(nxt);
      phase                    <= nxt;
      side_served              <= entering_side;
      if (entering_side)
        req_q <= 1'b0;
      else if (side_req && state != ST_SIDE_GRN)
        req_q <= 1'b1;
    end
  end

`ifdef PED_WALK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ped_q <= 1'b0;
      walk  <= 1'b0;
    end else begin
      if (entering_side)
        ped_q <= 1'b0;
      else if (ped_req && state != ST_SIDE_GRN)
        ped_q <= 1'b1;
      if (entering_side)
        walk <= ped_q;
      else if (nxt != ST_SIDE_GRN)
        walk <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_intersection_controller.sv
// Directed self-checking bench for intersection_controller.
// Build with +define+PED_WALK_EN to also exercise the walk output.
module tb_intersection_controller;

  logic       clk;
  logic       rst;
  logic       side_req;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic [2:0] phase;
  logic       side_served;
`ifdef PED_WALK_EN
  logic       ped_req;
  logic       walk;
`endif

  int checks   = 0;
  int failures = 0;

  intersection_controller dut (
    .clk         (clk),
    .rst         (rst),
    .side_req    (side_req),
`ifdef PED_WALK_EN
    .ped_req     (ped_req),
    .walk        (walk),
`endif
    .main_light  (main_light),
    .side_light  (side_light),
    .phase       (phase),
    .side_served (side_served)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference phase for cycle c after reset when a single request lands early.
  function automatic int exp_phase(input int c);
    if (c < 8)       return 0;
    else if (c < 11) return 1;
    else if (c < 12) return 2;
    else if (c < 18) return 3;
    else if (c < 21) return 4;
    else if (c < 22) return 5;
    else             return 0;
  endfunction

  function automatic logic [5:0] exp_lights(input int ph);
    case (ph)
      0:       return {3'b100, 3'b001};
      1:       return {3'b010, 3'b001};
      3:       return {3'b001, 3'b100};
      4:       return {3'b001, 3'b010};
      default: return {3'b001, 3'b001};
    endcase
  endfunction

  task automatic check_cycle(input string tag, input int c, input int ph, input bit served);
    logic [5:0] l;
    l = exp_lights(ph);
    chk($sformatf("%s.phase@%0d", tag, c), 32'(phase), 32'(ph));
    chk($sformatf("%s.main@%0d", tag, c), 32'(main_light), 32'(l[5:3]));
    chk($sformatf("%s.side@%0d", tag, c), 32'(side_light), 32'(l[2:0]));
    chk($sformatf("%s.served@%0d", tag, c), 32'(side_served), 32'(served));
    chk($sformatf("%s.safe@%0d", tag, c),
        32'((main_light != 3'b001) && (side_light != 3'b001)), 32'(0));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    side_req = 1'b0;
`ifdef PED_WALK_EN
    ped_req  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // mode 0: idle; 1: pulse at 2; 2: held; 3: pulses at 2 and 14; 4: ped pulse at 3
  task automatic run(input string tag, input int n, input int mode);
    for (int c = 0; c < n; c++) begin
      int k;
      int ep;
      k  = (mode == 2) ? (c % 22) : c;
      ep = (mode == 0) ? 0 : exp_phase(k);
      check_cycle(tag, c, ep, (mode != 0) && (k == 12));
`ifdef PED_WALK_EN
      chk($sformatf("%s.walk@%0d", tag, c), 32'(walk),
          32'((mode == 4) && (c >= 12) && (c <= 17)));
      ped_req = (mode == 4) && (c == 3);
`endif
      side_req = (mode == 1 && c == 2) || (mode == 2) ||
                 (mode == 3 && (c == 2 || c == 14));
      @(posedge clk);
      #1;
    end
    side_req = 1'b0;
`ifdef PED_WALK_EN
    ped_req = 1'b0;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    run("idle", 50, 0);

    do_reset();
    run("pulse", 30, 1);

    do_reset();
    run("held", 66, 2);

    do_reset();
    run("sgreq", 60, 3);

    // Reset in SIDE_YEL with a request present: request must be discarded.
    do_reset();
    run("t5pre", 19, 1);
    chk("t5.in_side_yel", 32'(phase), 32'(4));
    rst      = 1'b1;
    side_req = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    side_req = 1'b0;
    run("t5idle", 25, 0);

    // Reset in SIDE_YEL again: timer must restart so yellow begins at cycle 8.
    do_reset();
    run("t5pre2", 19, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run("t5timer", 24, 1);

`ifdef PED_WALK_EN
    do_reset();
    run("ped", 30, 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
